page_reg_ctrl_multi: RTL

Multi-channel successor to the single 3-bit page register controller used on the sound-CPU communication path. The CPU bus (nCS/nRD/nWR/MODE) is asynchronous to CLK; the block synchronises it and holds NUM_CH independent page registers. Each register supports direct load, auto-increment at the end of an access, configurable wrap/saturate at PAGE_MAX, a sticky overflow flag, and CPU readback.

---
 rtl/page_reg_ctrl_multi.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/page_reg_ctrl_multi.sv
// Multi-channel page register controller for the sound-CPU bus.
// Synchronises an asynchronous CPU strobe interface and holds NUM_CH independently incrementing page registers.
module page_reg_ctrl_multi #(
  parameter int PAGE_W   = 3,
  parameter int NUM_CH   = 2,
  parameter int PAGE_MAX = 7,
  parameter int WRAP     = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       nCS,
  input  logic                       nRD,
  input  logic                       nWR,
  input  logic                       MODE,
  input  logic [CH_W-1:0]            CHSEL,
  input  logic [PAGE_W-1:0]          DATA,
  output logic [PAGE_W:0]            DOUT,
  output logic                       DOE,
  output logic [NUM_CH*PAGE_W-1:0]   PAGEREG,
  output logic [NUM_CH-1:0]          OVF
);

  localparam int BUS_W = 4 + CH_W + PAGE_W;
  localparam logic [BUS_W-1:0] BUS_IDLE = {3'b111, {(BUS_W-3){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [BUS_W-1:0]   sync1_q;
  logic [BUS_W-1:0]   sync2_q;
  logic [1:0]         vld_q;

  state_t             state_q;
  logic               mode_q;
  logic               wr_q;
  logic [CH_W-1:0]    ch_q;
  logic [PAGE_W-1:0]  data_q;
  logic               acc_hi_q;
  logic [PAGE_W-1:0]  pg_q [NUM_CH];
  logic [NUM_CH-1:0]  ovf_q;
  logic [PAGE_W:0]    dout_q;
  logic               doe_q;

  logic               s_ncs;
  logic               s_nrd;
  logic               s_nwr;
  logic               s_mode;
  logic [CH_W-1:0]    s_ch;
  logic [PAGE_W-1:0]  s_data;
  logic               s_acc;

  logic               ch_ok_d;
  logic [PAGE_W-1:0]  cur_pg_d;
  logic               cur_ovf_d;
  logic               at_max_d;
  logic [PAGE_W-1:0]  inc_pg_d;
  logic [PAGE_W:0]    rd_val_d;

  // Whole bus goes through one 2-FF pipe so strobes, select and data stay aligned.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= BUS_IDLE;
      sync2_q <= BUS_IDLE;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= {nCS, nRD, nWR, MODE, CHSEL, DATA};
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  assign {s_ncs, s_nrd, s_nwr, s_mode, s_ch, s_data} = sync2_q;
  assign s_acc = s_nrd & s_nwr;

  // Selected-channel view and the increment result for the latched channel.
  always_comb begin
    cur_pg_d  = {PAGE_W{1'b0}};
    cur_ovf_d = 1'b0;
    ch_ok_d   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        cur_pg_d  = pg_q[i];
        cur_ovf_d = ovf_q[i];
        ch_ok_d   = 1'b1;
      end else begin
        cur_pg_d  = cur_pg_d;
      end
    end
    at_max_d = (int'(cur_pg_d) >= PAGE_MAX);
    if (!at_max_d) begin
      inc_pg_d = cur_pg_d + PAGE_W'(1);
    end else if (WRAP != 0) begin
      inc_pg_d = {PAGE_W{1'b0}};
    end else begin
      inc_pg_d = cur_pg_d;
    end
    if (ch_ok_d) begin
      rd_val_d = {cur_ovf_d, cur_pg_d};
    end else begin
      rd_val_d = {(PAGE_W+1){1'b0}};
    end
  end

  // Access FSM, page registers and registered readback.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      wr_q     <= 1'b0;
      ch_q     <= {CH_W{1'b0}};
      data_q   <= {PAGE_W{1'b0}};
      acc_hi_q <= 1'b0;
      ovf_q    <= {NUM_CH{1'b0}};
      dout_q   <= {(PAGE_W+1){1'b0}};
      doe_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pg_q[i] <= {PAGE_W{1'b0}};
      end
    end else begin
      // A strobe held low through reset must be seen high before it can start an access.
      if (s_acc && vld_q[1]) begin
        acc_hi_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          doe_q  <= 1'b0;
          dout_q <= {(PAGE_W+1){1'b0}};
          if (!s_acc && !s_ncs && acc_hi_q) begin
            state_q  <= ACTIVE;
            mode_q   <= s_mode;
            wr_q     <= ~s_nwr;
            ch_q     <= s_ch;
            data_q   <= s_data;
            acc_hi_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (s_acc) begin
            state_q <= COMMIT;
            doe_q   <= 1'b0;
            dout_q  <= {(PAGE_W+1){1'b0}};
          end else if (s_ncs) begin
            state_q <= IDLE;
            doe_q   <= 1'b0;
            dout_q  <= {(PAGE_W+1){1'b0}};
          end else begin
            data_q <= s_data;
            if (!mode_q && !wr_q) begin
              doe_q  <= 1'b1;
              dout_q <= rd_val_d;
            end else begin
              doe_q  <= 1'b0;
              dout_q <= {(PAGE_W+1){1'b0}};
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          doe_q   <= 1'b0;
          dout_q  <= {(PAGE_W+1){1'b0}};
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
              if (mode_q) begin
                pg_q[i] <= inc_pg_d;
                if (at_max_d) begin
                  ovf_q[i] <= 1'b1;
                end
              end else if (wr_q) begin
                pg_q[i]  <= data_q;
                ovf_q[i] <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          doe_q   <= 1'b0;
          dout_q  <= {(PAGE_W+1){1'b0}};
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign PAGEREG[g*PAGE_W +: PAGE_W] = pg_q[g];
  end

  assign OVF  = ovf_q;
  assign DOUT = dout_q;
  assign DOE  = doe_q;

endmodule
